// File: rtl/myo_sched_pkg.sv
// ----------------------------------------------------------------------------
// myo_sched_pkg
// Shared types and constants for the myo SPI poll scheduler.
//   sched_state_t : scheduler FSM states
//   MOTOR_IDX_W   : width of every motor index output
//   SWEEP_CNT_MAX : saturation value of the 32-bit sweep counter
//   sat_inc()     : saturating +1 used for the sweep counter
// ----------------------------------------------------------------------------
package myo_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      START,
      WAIT,
      PACE
   } sched_state_t;

   localparam int          MOTOR_IDX_W   = 8;
   localparam logic [31:0] SWEEP_CNT_MAX = 32'hFFFF_FFFF;

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == SWEEP_CNT_MAX) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/myo_sweep_timer.sv
// ----------------------------------------------------------------------------
// myo_sweep_timer
// Saturating sweep-length counter with period compare and overrun flag.
//   clock, reset    : system clock, asynchronous active-high reset
//   cnt_clear       : restart the counter (counter reads 0 next cycle)
//   sweep_end       : current cycle is the last of a sweep; capture length
//   clear_flags     : clears the sticky overrun flag (a new overrun wins)
//   period_cycles   : sweep period, 0 = free-run
//   period_reached  : counter+1 has reached the period (or free-run)
//   sweep_cycles    : length of the last completed sweep in clocks
//   overrun         : sticky, a sweep was longer than a non-zero period
// ----------------------------------------------------------------------------
module myo_sweep_timer
   import myo_sched_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        cnt_clear,
   input  logic        sweep_end,
   input  logic        clear_flags,
   input  logic [31:0] period_cycles,
   output logic        period_reached,
   output logic [31:0] sweep_cycles,
   output logic        overrun
);

   logic [31:0] count_q, count_d;
   logic [31:0] sweep_cycles_q, sweep_cycles_d;
   logic        overrun_q, overrun_d;
   logic [31:0] count_inc;

   // count_inc is the number of cycles elapsed including the current one.
   assign count_inc      = sat_inc(count_q);
   assign period_reached = (period_cycles == 32'd0) || (count_inc >= period_cycles);

   always_comb begin
      count_d        = cnt_clear ? 32'd0 : count_inc;
      sweep_cycles_d = sweep_end ? count_inc : sweep_cycles_q;
      overrun_d      = overrun_q;
      if (clear_flags) begin
         overrun_d = 1'b0;
      end
      if (sweep_end && (period_cycles != 32'd0) && (count_inc > period_cycles)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q        <= 32'd0;
         sweep_cycles_q <= 32'd0;
         overrun_q      <= 1'b0;
      end else begin
         count_q        <= count_d;
         sweep_cycles_q <= sweep_cycles_d;
         overrun_q      <= overrun_d;
      end
   end

   assign sweep_cycles = sweep_cycles_q;
   assign overrun      = overrun_q;

endmodule

// File: rtl/myo_poll_scheduler.sv
// ----------------------------------------------------------------------------
// myo_poll_scheduler
// Walks the enabled motors of one myo SPI bus in index order, requests one
// SPI frame per motor, emits latch / pid_update on frame completion and paces
// full sweeps to period_cycles. A per-frame watchdog guards against a stuck
// SpiControl.
//   clock, reset    : system clock, asynchronous active-high reset
//   enable          : scheduling allowed
//   motor_mask      : 1 = motor polled
//   period_cycles   : sweep period in clocks, 0 = free-run
//   spi_done        : SpiControl idle/done level
//   clear_flags     : clears timeout and overrun
//   start           : one-cycle frame request
//   motor           : index of current/last frame (valid with start)
//   latch           : one-cycle, capture received values for motor
//   pid_update      : one-cycle, one clock after latch, for pid_motor
//   pid_motor       : motor that pid_update refers to
//   busy            : scheduler not idle
//   sweep_cycles    : length of last completed sweep
//   timeout         : sticky, frame watchdog expired
//   timeout_motor   : motor of the most recent timeout
//   overrun         : sticky, sweep exceeded non-zero period
// ----------------------------------------------------------------------------
module myo_poll_scheduler
   import myo_sched_pkg::*;
#(
   parameter int NUMBER_OF_MOTORS = 6,
   parameter int TIMEOUT_CYCLES   = 5000
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
   input  logic [31:0]                 period_cycles,
   input  logic                        spi_done,
   input  logic                        clear_flags,
   output logic                        start,
   output logic [MOTOR_IDX_W-1:0]      motor,
   output logic                        latch,
   output logic                        pid_update,
   output logic [MOTOR_IDX_W-1:0]      pid_motor,
   output logic                        busy,
   output logic [31:0]                 sweep_cycles,
   output logic                        timeout,
   output logic [MOTOR_IDX_W-1:0]      timeout_motor,
   output logic                        overrun
);

   localparam logic [MOTOR_IDX_W-1:0] END_IDX    = MOTOR_IDX_W'(NUMBER_OF_MOTORS);
   localparam logic [31:0]            WDOG_LIMIT = 32'(TIMEOUT_CYCLES - 1);

   sched_state_t           state_q, state_d;
   logic [MOTOR_IDX_W-1:0] idx_q, idx_d;
   logic [MOTOR_IDX_W-1:0] motor_q, motor_d;
   logic [MOTOR_IDX_W-1:0] pid_motor_q, pid_motor_d;
   logic                   pid_update_q, pid_update_d;
   logic [31:0]            wdog_q, wdog_d;
   logic                   done_q, done_prev_q;
   logic                   timeout_q, timeout_d;
   logic [MOTOR_IDX_W-1:0] timeout_motor_q, timeout_motor_d;

   logic         done_rise;
   logic         mask_any;
   logic         mask_bit;
   logic [255:0] mask_ext;
   logic         cnt_clear;
   logic         sweep_end;
   logic         period_reached;

   // Zero-extended so idx == NUMBER_OF_MOTORS never indexes out of range.
   assign mask_ext  = 256'(motor_mask);
   assign mask_bit  = mask_ext[idx_q];
   assign mask_any  = |motor_mask;
   assign done_rise = done_q & ~done_prev_q;

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      motor_d         = motor_q;
      pid_motor_d     = pid_motor_q;
      wdog_d          = wdog_q;
      timeout_d       = clear_flags ? 1'b0 : timeout_q;
      timeout_motor_d = timeout_motor_q;
      start           = 1'b0;
      latch           = 1'b0;
      cnt_clear       = 1'b0;
      sweep_end       = 1'b0;

      case (state_q)
         IDLE: begin
            idx_d     = '0;
            cnt_clear = 1'b1;
            if (enable && mask_any) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            // enable is checked first so a dropped enable never issues another start.
            if (!enable) begin
               state_d = IDLE;
            end else if (idx_q == END_IDX) begin
               sweep_end = 1'b1;
               state_d   = PACE;
            end else if (mask_bit) begin
               motor_d = idx_q;   // valid together with the start pulse
               state_d = START;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         START: begin
            start   = 1'b1;
            wdog_d  = 32'd0;
            state_d = WAIT;
         end
         WAIT: begin
            if (done_rise) begin
               latch       = 1'b1;
               pid_motor_d = idx_q;
               idx_d       = idx_q + 1'b1;
               state_d     = SCAN;
            end else if (wdog_q == WDOG_LIMIT) begin
               timeout_d       = 1'b1;
               timeout_motor_d = idx_q;
               idx_d           = idx_q + 1'b1;
               state_d         = SCAN;
            end else begin
               wdog_d = wdog_q + 32'd1;
            end
         end
         PACE: begin
            if (!enable || !mask_any) begin
               state_d = IDLE;
            end else if (period_reached) begin
               cnt_clear = 1'b1;
               idx_d     = '0;
               state_d   = SCAN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      pid_update_d = latch;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         idx_q           <= '0;
         motor_q         <= '0;
         pid_motor_q     <= '0;
         pid_update_q    <= 1'b0;
         wdog_q          <= 32'd0;
         // Edge register resets high so a low-then-high spi_done after reset
         // is the only thing that can look like a completion.
         done_q          <= 1'b1;
         done_prev_q     <= 1'b1;
         timeout_q       <= 1'b0;
         timeout_motor_q <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         motor_q         <= motor_d;
         pid_motor_q     <= pid_motor_d;
         pid_update_q    <= pid_update_d;
         wdog_q          <= wdog_d;
         done_q          <= spi_done;
         done_prev_q     <= done_q;
         timeout_q       <= timeout_d;
         timeout_motor_q <= timeout_motor_d;
      end
   end

   myo_sweep_timer u_sweep_timer (
      .clock          (clock),
      .reset          (reset),
      .cnt_clear      (cnt_clear),
      .sweep_end      (sweep_end),
      .clear_flags    (clear_flags),
      .period_cycles  (period_cycles),
      .period_reached (period_reached),
      .sweep_cycles   (sweep_cycles),
      .overrun        (overrun)
   );

   assign motor         = motor_q;
   assign pid_motor     = pid_motor_q;
   assign pid_update    = pid_update_q;
   assign busy          = (state_q != IDLE);
   assign timeout       = timeout_q;
   assign timeout_motor = timeout_motor_q;

endmodule

// File: tb/tb_myo_poll_scheduler.sv
// ----------------------------------------------------------------------------
// tb_myo_poll_scheduler
// Scoreboard bench: stimulus pushes expected start/latch motors into queues,
// a negedge monitor pops and compares whenever the DUT pulses start or latch.
// Frame responder drops spi_done for FRAME cycles after each start.
// ----------------------------------------------------------------------------
module tb_myo_poll_scheduler;

   localparam int N     = 6;
   localparam int TMO   = 5000;
   localparam int FRAME = 100;
   localparam int LIMIT = 20000;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [N-1:0]  motor_mask = '1;
   logic [31:0]   period_cycles = 32'd0;
   logic          spi_done = 1'b1;
   logic          clear_flags = 1'b0;
   logic          start;
   logic [7:0]    motor;
   logic          latch;
   logic          pid_update;
   logic [7:0]    pid_motor;
   logic          busy;
   logic [31:0]   sweep_cycles;
   logic          timeout;
   logic [7:0]    timeout_motor;
   logic          overrun;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int silent_motor = -1;
   int exp_start[$];
   int exp_latch[$];
   int s0_cyc[$];
   int start_cyc[N];
   bit pid_pend = 1'b0;
   int pid_exp = 0;

   myo_poll_scheduler #(
      .NUMBER_OF_MOTORS (N),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .motor_mask    (motor_mask),
      .period_cycles (period_cycles),
      .spi_done      (spi_done),
      .clear_flags   (clear_flags),
      .start         (start),
      .motor         (motor),
      .latch         (latch),
      .pid_update    (pid_update),
      .pid_motor     (pid_motor),
      .busy          (busy),
      .sweep_cycles  (sweep_cycles),
      .timeout       (timeout),
      .timeout_motor (timeout_motor),
      .overrun       (overrun)
   );

   initial forever #5 clock = ~clock;
   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   task automatic flag_fail(input string msg);
      tests++;
      fails++;
      $display("FAIL %s", msg);
   endtask

   // Frame responder: SpiControl goes busy right after start, done FRAME cycles later.
   initial forever begin
      @(negedge clock);
      if (start && !reset && int'(motor) != silent_motor) begin
         spi_done = 1'b0;
         repeat (FRAME) @(negedge clock);
         spi_done = 1'b1;
      end
   end

   // Monitor / scoreboard.
   initial forever begin
      int e;
      @(negedge clock);
      if (!reset) begin
         if (start && latch) flag_fail("start_latch_overlap: both high in one cycle");
         if (pid_pend) begin
            chk("pid_update_after_latch", pid_update, 1);
            chk("pid_motor", pid_motor, pid_exp);
            pid_pend = 1'b0;
         end else if (pid_update) begin
            flag_fail($sformatf("spurious_pid_update: pid_motor %0d", pid_motor));
         end
         if (start) begin
            if (exp_start.size() == 0) begin
               flag_fail($sformatf("unexpected_start: motor %0d, none expected", motor));
            end else begin
               e = exp_start.pop_front();
               chk("start_motor", motor, e);
               if (motor < N) start_cyc[motor] = cyc;
               if (motor == 8'd0) s0_cyc.push_back(cyc);
            end
         end
         if (latch) begin
            if (exp_latch.size() == 0) begin
               flag_fail($sformatf("unexpected_latch: motor %0d, none expected", motor));
            end else begin
               e = exp_latch.pop_front();
               chk("latch_motor", motor, e);
               pid_pend = 1'b1;
               pid_exp  = e;
            end
         end
      end
   end

   task automatic push_sweeps(input logic [N-1:0] mask, input int sweeps);
      for (int s = 0; s < sweeps; s++) begin
         for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
               exp_start.push_back(i);
               if (i != silent_motor) exp_latch.push_back(i);
            end
         end
      end
   endtask

   task automatic wait_starts(input int left);
      for (int c = 0; exp_start.size() > left; c++) begin
         if (c >= LIMIT) begin
            flag_fail($sformatf("wait_starts_timeout: %0d starts still pending", exp_start.size()));
            exp_start.delete();
            break;
         end
         @(posedge clock);
      end
   endtask

   // Wait for the expected starts, drop enable, let the last frame latch,
   // then the scheduler must be idle two cycles after that latch.
   task automatic finish_run(input int drop_delay);
      wait_starts(0);
      repeat (drop_delay) @(posedge clock);
      #1 enable = 1'b0;
      for (int c = 0; exp_latch.size() > 0; c++) begin
         if (c >= LIMIT) begin
            flag_fail($sformatf("wait_latch_timeout: %0d latches still pending", exp_latch.size()));
            exp_latch.delete();
            break;
         end
         @(posedge clock);
      end
      @(posedge clock);
      #1 chk("busy_after_stop", busy, 0);
      repeat (20) @(posedge clock);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_start", start, 0);
      chk("rst_latch", latch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_motor", motor, 0);
      chk("rst_sweep_cycles", sweep_cycles, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_overrun", overrun, 0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      #1;

      // Free-run, all motors: 6 frames * (FRAME+3) + final scan = 619.
      push_sweeps(6'h3F, 2);
      motor_mask = 6'h3F;
      enable = 1'b1;
      finish_run(0);
      chk("sweep_cycles_full", sweep_cycles, 619);

      // Sparse mask: 3 frames * 103 + 3 skipped + final scan = 313.
      push_sweeps(6'b100101, 2);
      motor_mask = 6'b100101;
      enable = 1'b1;
      finish_run(0);
      chk("sweep_cycles_sparse", sweep_cycles, 313);

      // Enable dropped 10 cycles into motor 2's frame.
      motor_mask = 6'h3F;
      for (int i = 0; i < 3; i++) begin
         exp_start.push_back(i);
         exp_latch.push_back(i);
      end
      enable = 1'b1;
      finish_run(10);
      repeat (150) @(posedge clock);
      #1;

      // Silent responder for motor 3: watchdog fires, motor 4 follows.
      silent_motor = 3;
      push_sweeps(6'h3F, 1);
      enable = 1'b1;
      finish_run(0);
      chk("timeout_flag", timeout, 1);
      chk("timeout_motor", timeout_motor, 3);
      chk("timeout_start_gap", start_cyc[4] - start_cyc[3], TMO + 2);
      silent_motor = -1;
      clear_flags = 1'b1;
      @(posedge clock);
      #1 clear_flags = 1'b0;
      chk("timeout_cleared", timeout, 0);

      // Paced sweeps: starts exactly one period apart.
      period_cycles = 32'd1000;
      s0_cyc.delete();
      push_sweeps(6'h3F, 3);
      enable = 1'b1;
      finish_run(0);
      if (s0_cyc.size() >= 3) begin
         chk("period_gap_1", s0_cyc[1] - s0_cyc[0], 1000);
         chk("period_gap_2", s0_cyc[2] - s0_cyc[1], 1000);
      end else begin
         flag_fail($sformatf("period_sweeps: %0d sweep starts seen, 3 required", s0_cyc.size()));
      end
      chk("overrun_in_period", overrun, 0);

      // Short period: overrun, back-to-back sweeps, clear then re-set.
      period_cycles = 32'd100;
      s0_cyc.delete();
      push_sweeps(6'h3F, 3);
      enable = 1'b1;
      wait_starts(9);
      #1 chk("overrun_set", overrun, 1);
      @(posedge clock);
      #1 clear_flags = 1'b1;
      @(posedge clock);
      #1 clear_flags = 1'b0;
      chk("overrun_cleared", overrun, 0);
      wait_starts(3);
      #1 chk("overrun_reset_again", overrun, 1);
      finish_run(0);
      if (s0_cyc.size() >= 3) begin
         chk("b2b_gap_1", s0_cyc[1] - s0_cyc[0], 620);
         chk("b2b_gap_2", s0_cyc[2] - s0_cyc[1], 620);
      end else begin
         flag_fail($sformatf("b2b_sweeps: %0d sweep starts seen, 3 required", s0_cyc.size()));
      end

      // Reset in the middle of a frame.
      period_cycles = 32'd0;
      exp_start.push_back(0);
      enable = 1'b1;
      wait_starts(0);
      repeat (20) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_start", start, 0);
      chk("midrst_latch", latch, 0);
      chk("midrst_pid_motor", pid_motor, 0);
      chk("midrst_sweep_cycles", sweep_cycles, 0);
      chk("midrst_overrun", overrun, 0);
      chk("midrst_timeout_motor", timeout_motor, 0);
      exp_start.push_back(0);
      @(negedge clock) reset = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("post_rst_start", start, 1);
      chk("post_rst_motor", motor, 0);
      @(negedge clock);
      #1 chk("scoreboard_drained", exp_start.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
